// File: rtl/mux_datasrc_reg_if.sv
// ============================================================================
// mux_datasrc_reg_if : source-select / valid-ready bus for mux_datasrc_reg
// Rev 1.0
// ============================================================================
`default_nettype none

interface mux_datasrc_reg_if #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2,
  parameter int ERR_W = 8
);
  logic [SEL_W-1:0]      sel;
  logic [N_IN*WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sel_err;
  logic [ERR_W-1:0]      err_count;

  modport master (
    output sel, in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, sel_err, err_count
  );

  modport slave (
    input  sel, in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, sel_err, err_count
  );
endinterface

`default_nettype wire

// File: rtl/mux_datasrc_reg.sv
// ============================================================================
// mux_datasrc_reg : registered N-way source select feeding a 2-entry skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_datasrc_reg #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = 2,
  parameter int ERR_W = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mux_datasrc_reg_if.slave  bus
);

  localparam int unsigned N_IN_U = N_IN;

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic             sel_err_q, sel_err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [31:0]      w_sel_ext;
  logic             w_sel_ok;
  logic [WIDTH-1:0] w_value;
  logic             w_in_ready;
  logic             w_acc;
  logic             w_xfer;

  // Ready depends only on registered state, so out_ready never reaches in_ready.
  assign w_in_ready = !skid_valid_q;
  assign w_acc      = bus.in_valid & w_in_ready;
  assign w_xfer     = main_valid_q & bus.out_ready;

  assign w_sel_ext  = 32'(bus.sel);
  assign w_sel_ok   = (w_sel_ext < N_IN_U);

  always_comb begin
    w_value = '0;
    for (int unsigned i = 0; i < N_IN_U; i++) begin
      if (w_sel_ext == i) begin
        w_value = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    main_data_d  = main_data_q;
    main_valid_d = main_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;

    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      // Skid is never occupied while main is empty.
      if (w_acc) begin
        main_data_d  = w_value;
        main_valid_d = 1'b1;
      end
    end else if (w_xfer) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (w_acc) begin
        main_data_d  = w_value;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (w_acc) begin
      skid_data_d  = w_value;
      skid_valid_d = 1'b1;
    end
  end

  // Select errors are tracked on every accepted beat, even one that a flush discards.
  always_comb begin
    sel_err_d   = w_acc & !w_sel_ok;
    err_count_d = err_count_q;
    if (sel_err_d && (err_count_q != {ERR_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_data_q  <= '0;
      main_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      sel_err_q    <= 1'b0;
      err_count_q  <= '0;
    end else begin
      main_data_q  <= main_data_d;
      main_valid_q <= main_valid_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      sel_err_q    <= sel_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = main_data_q;
  assign bus.out_valid = main_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_datasrc_reg.sv
// ============================================================================
// tb_mux_datasrc_reg : directed checks of mux_datasrc_reg (N_IN=4 and N_IN=3)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_datasrc_reg;

  logic clk;
  logic reset;
  int   n_err;
  int   n_chk;
  logic [31:0] cha [4];

  mux_datasrc_reg_if #(.WIDTH(32), .N_IN(4), .SEL_W(2), .ERR_W(8)) ifa ();
  mux_datasrc_reg_if #(.WIDTH(32), .N_IN(3), .SEL_W(2), .ERR_W(8)) ifb ();

  mux_datasrc_reg #(.WIDTH(32), .N_IN(4), .SEL_W(2), .ERR_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  mux_datasrc_reg #(.WIDTH(32), .N_IN(3), .SEL_W(2), .ERR_W(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    cha[0] = 32'h11111111;
    cha[1] = 32'hA5A5A5A5;
    cha[2] = 32'h0000BEEF;
    cha[3] = 32'hCAFEF00D;

    reset         = 1'b1;
    ifa.sel       = '0;
    ifa.in_data   = {cha[3], cha[2], cha[1], cha[0]};
    ifa.in_valid  = 1'b0;
    ifa.flush     = 1'b0;
    ifa.out_ready = 1'b1;
    ifb.sel       = '0;
    ifb.in_data   = {32'h00000030, 32'h00000020, 32'h00000010};
    ifb.in_valid  = 1'b0;
    ifb.flush     = 1'b0;
    ifb.out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", ifa.out_valid, 1'b0);
    chk("rst_in_ready",  ifa.in_ready,  1'b1);
    chk("rst_out_data",  ifa.out_data,  32'h0);
    chk("rst_sel_err",   ifa.sel_err,   1'b0);
    chk("rst_err_count", ifa.err_count, 8'd0);
    reset = 1'b0;
    tick();

    // Basic select, latency 1
    ifa.sel = 2'd1; ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    tick();
    chk("basic_valid",   ifa.out_valid, 1'b1);
    chk("basic_data",    ifa.out_data,  32'hA5A5A5A5);
    chk("basic_sel_err", ifa.sel_err,   1'b0);
    ifa.in_valid = 1'b0;
    tick();
    chk("basic_drain",   ifa.out_valid, 1'b0);

    // Back-pressure: fill main then skid, third beat must wait
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.sel = 2'd0;
    tick();
    chk("bp_ready_1",  ifa.in_ready, 1'b1);
    ifa.sel = 2'd1;
    tick();
    chk("bp_ready_2",  ifa.in_ready, 1'b0);
    ifa.sel = 2'd2;
    tick();
    chk("bp_hold_data", ifa.out_data, 32'h11111111);
    chk("bp_hold_rdy",  ifa.in_ready, 1'b0);
    ifa.out_ready = 1'b1;
    tick();
    chk("bp_second",     ifa.out_data, 32'hA5A5A5A5);
    chk("bp_ready_back", ifa.in_ready, 1'b1);
    tick();
    chk("bp_third",       ifa.out_data,  32'h0000BEEF);
    chk("bp_third_valid", ifa.out_valid, 1'b1);
    ifa.in_valid = 1'b0;
    tick();
    chk("bp_drain", ifa.out_valid, 1'b0);

    // Full throughput with rotating sel
    ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ifa.sel = 2'(k);
      tick();
      chk("tp_valid", ifa.out_valid, 1'b1);
      chk("tp_data",  ifa.out_data,  cha[k % 4]);
      chk("tp_ready", ifa.in_ready,  1'b1);
    end
    ifa.in_valid = 1'b0;
    tick();
    chk("tp_drain", ifa.out_valid, 1'b0);

    // Flush with main and skid full; offered beat has a valid sel
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.sel = 2'd0;
    tick();
    ifa.sel = 2'd1;
    tick();
    chk("fl_full", ifa.in_ready, 1'b0);
    ifa.flush = 1'b1; ifa.sel = 2'd3;
    tick();
    chk("fl_valid",  ifa.out_valid, 1'b0);
    chk("fl_ready",  ifa.in_ready,  1'b1);
    chk("fl_errcnt", ifa.err_count, 8'd0);
    ifa.flush = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
    tick();
    chk("fl_absent", ifa.out_valid, 1'b0);

    // Flush discards a beat accepted in the same cycle
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.sel = 2'd0;
    tick();
    ifa.flush = 1'b1; ifa.sel = 2'd2;
    tick();
    ifa.flush = 1'b0; ifa.in_valid = 1'b0;
    tick();
    chk("fl_acc_absent", ifa.out_valid, 1'b0);
    chk("fl_acc_ready",  ifa.in_ready,  1'b1);

    // Out-of-range on N_IN=3
    ifb.sel = 2'd2; ifb.in_valid = 1'b1;
    tick();
    chk("oor_ok_data", ifb.out_data, 32'h30);
    chk("oor_ok_err",  ifb.sel_err,  1'b0);
    ifb.sel = 2'd3;
    tick();
    chk("oor_data",   ifb.out_data,  32'h0);
    chk("oor_valid",  ifb.out_valid, 1'b1);
    chk("oor_pulse",  ifb.sel_err,   1'b1);
    chk("oor_count1", ifb.err_count, 8'd1);
    ifb.in_valid = 1'b0;
    tick();
    chk("oor_pulse_end", ifb.sel_err,   1'b0);
    chk("oor_count_hold", ifb.err_count, 8'd1);

    // Flushed bad beat is still counted and pulsed
    ifb.flush = 1'b1; ifb.in_valid = 1'b1; ifb.sel = 2'd3;
    tick();
    chk("oor_fl_valid", ifb.out_valid, 1'b0);
    chk("oor_fl_pulse", ifb.sel_err,   1'b1);
    chk("oor_fl_count", ifb.err_count, 8'd2);
    ifb.flush = 1'b0;

    // Saturation: 2 + 300 bad beats clamp at 255
    for (int k = 0; k < 300; k++) begin
      tick();
    end
    ifb.in_valid = 1'b0;
    tick();
    chk("oor_sat", ifb.err_count, 8'd255);

    // Asynchronous reset between edges
    ifa.out_ready = 1'b0; ifa.in_valid = 1'b1; ifa.sel = 2'd1;
    ifb.in_valid = 1'b1; ifb.sel = 2'd3;
    tick();
    ifa.sel = 2'd2;
    tick();
    chk("ar_pre_valid", ifa.out_valid, 1'b1);
    chk("ar_pre_err",   ifb.sel_err,   1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid",   ifa.out_valid, 1'b0);
    chk("ar_ready",   ifa.in_ready,  1'b1);
    chk("ar_sel_err", ifb.sel_err,   1'b0);
    chk("ar_errcnt",  ifb.err_count, 8'd0);
    reset = 1'b0;
    ifb.in_valid = 1'b0;
    ifa.sel = 2'd3; ifa.out_ready = 1'b1;
    tick();
    chk("ar_lat_valid", ifa.out_valid, 1'b1);
    chk("ar_lat_data",  ifa.out_data,  32'hCAFEF00D);
    ifa.in_valid = 1'b0;
    tick();
    chk("ar_drain", ifa.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
